// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared constants, fetch FSM state type and PC helpers for the
//            RV32I fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_t;

    // Instructions are word aligned; low address bits of a target are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// Module   : fetch_skid_buf
// Brief    : One-entry {pc, inst} holding buffer between the fetch response
//            path and the IF/ID output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_pc,
    input  logic [31:0]     push_inst,
    output logic            full,
    output logic [XLEN-1:0] head_pc,
    output logic [31:0]     head_inst
);

    logic            r_full;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;

    // Clear wins over everything; a push alongside a pop replaces the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_pc   <= '0;
            r_inst <= '0;
        end else if (clear) begin
            r_full <= 1'b0;
        end else if (push) begin
            r_full <= 1'b1;
            r_pc   <= push_pc;
            r_inst <= push_inst;
        end else if (pop) begin
            r_full <= 1'b0;
        end
    end

    assign full      = r_full;
    assign head_pc   = r_pc;
    assign head_inst = r_inst;

endmodule

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module   : fetch_pc_unit
// Brief    : IF-stage PC generator with single-outstanding instruction fetch,
//            branch redirect/flush and a skid-buffered IF/ID output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_inst,
    output logic            flush,
    output logic            misalign
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [31:0]     r_if_inst;
    logic            r_misalign;

    logic            w_skid_full;
    logic [XLEN-1:0] w_skid_pc;
    logic [31:0]     w_skid_inst;
    logic            w_req;
    logic            w_grant;
    logic            w_deliver;
    logic            w_out_free;
    logic            w_skid_pop;
    logic            w_deliver_to_out;
    logic            w_skid_push;
    logic [XLEN-1:0] w_target;

    // A full skid buffer means the pipeline is backed up: stop requesting.
    assign w_req    = (r_state == S_FETCH) && !w_skid_full;
    assign w_grant  = w_req && imem_gnt;
    assign w_target = align_pc(branch_target);

    // A response in WAIT is the live one unless a redirect kills it this cycle.
    assign w_deliver = (r_state == S_WAIT) && imem_rvalid && !branch_taken;

    assign w_out_free       = !r_if_valid || !stall;
    assign w_skid_pop       = !branch_taken && !stall && w_skid_full;
    assign w_deliver_to_out = w_deliver && w_out_free && !w_skid_full;
    assign w_skid_push      = w_deliver && !w_deliver_to_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (w_grant) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + XLEN'(4);
                        r_state  <= branch_taken ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_FETCH;
                    end else if (branch_taken) begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Redirect overrides the sequential increment above.
            if (branch_taken) begin
                r_pc <= w_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= RESET_PC;
            r_if_inst  <= INST_NOP;
        end else if (branch_taken) begin
            r_if_valid <= 1'b0;
        end else if (w_skid_pop) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= w_skid_pc;
            r_if_inst  <= w_skid_inst;
        end else if (w_deliver_to_out) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_req_pc;
            r_if_inst  <= imem_rdata;
        end else if (!stall) begin
            r_if_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= branch_taken && is_misaligned(branch_target);
        end
    end

    fetch_skid_buf #(
        .XLEN (XLEN)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (branch_taken),
        .push      (w_skid_push),
        .pop       (w_skid_pop),
        .push_pc   (r_req_pc),
        .push_inst (imem_rdata),
        .full      (w_skid_full),
        .head_pc   (w_skid_pc),
        .head_inst (w_skid_inst)
    );

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_inst   = r_if_inst;
    assign flush     = branch_taken;
    assign misalign  = r_misalign;

endmodule

`default_nettype wire
